// File: rtl/systolic_drain.sv
// systolic_drain: captures per-row result streams from the systolic array into
// per-row FIFOs and serialises them row-major per patch onto a valid/ready
// stream carrying a linear result address and an end-of-patch marker.
// Optional feature: define SYSTOLIC_DRAIN_SAT_EN for unsigned saturation of
// m_data; otherwise m_data is the truncated low D_W_OUT bits of the result.
module systolic_drain #(
  parameter int D_W_ACC    = 16,
  parameter int D_W_OUT    = 8,
  parameter int N1         = 4,
  parameter int N2         = 4,
  parameter int M          = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [D_W_ACC-1:0]         D [N1-1:0],
  input  logic [N1-1:0]              valid_D,
  output logic [D_W_OUT-1:0]         m_data,
  output logic [$clog2(M*M)-1:0]     m_addr,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic                       m_last,
  output logic                       done,
  output logic [N1-1:0]              overflow
);

  localparam int PA = $clog2(FIFO_DEPTH);
  localparam int AW = $clog2(M*M);
  localparam int NP = (M*M)/(N1*N2);
  localparam int RW = (N1 > 1) ? $clog2(N1) : 1;
  localparam int BW = (N2 > 1) ? $clog2(N2) : 1;
  localparam int PW = (NP > 1) ? $clog2(NP) : 1;

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t              state;
  logic [RW-1:0]       row;
  logic [BW-1:0]       beat;
  logic [PW-1:0]       patch;

  logic [D_W_ACC-1:0]  mem    [N1][FIFO_DEPTH];
  logic [PA:0]         wr_ptr [N1];
  logic [PA:0]         rd_ptr [N1];
  logic [N1-1:0]       empty;
  logic [N1-1:0]       full;
  logic [N1-1:0]       pop;
  logic [N1-1:0]       push_ok;
  logic [PA-1:0]       rd_idx;
  logic [D_W_ACC-1:0]  head;
  logic [D_W_OUT-1:0]  out_val;
  logic                hs;
  logic                last_beat;

  // FIFO status, pop/push qualification and the current-row head
  always_comb begin
    empty   = '0;
    full    = '0;
    pop     = '0;
    push_ok = '0;
    m_valid = !empty_row(row);
    hs      = m_valid && m_ready;
    for (int unsigned i = 0; i < N1; i++) begin
      empty[i]   = (wr_ptr[i] == rd_ptr[i]);
      full[i]    = (wr_ptr[i][PA] != rd_ptr[i][PA]) &&
                   (wr_ptr[i][PA-1:0] == rd_ptr[i][PA-1:0]);
      pop[i]     = hs && (row == RW'(i));
      // a full FIFO still accepts a push when it is popped in the same cycle
      push_ok[i] = valid_D[i] && (!full[i] || pop[i]);
    end
    rd_idx = rd_ptr[row][PA-1:0];
    head   = mem[row][rd_idx];
  end

  function automatic logic empty_row(input logic [RW-1:0] r);
    return wr_ptr[r] == rd_ptr[r];
  endfunction

`ifdef SYSTOLIC_DRAIN_SAT_EN
  assign out_val = (|head[D_W_ACC-1:D_W_OUT]) ? '1 : head[D_W_OUT-1:0];
`else
  logic unused_hi;
  assign unused_hi = ^head[D_W_ACC-1:D_W_OUT];
  assign out_val   = head[D_W_OUT-1:0];
`endif

  // Output beat: data forced to zero while nothing is presented
  always_comb begin
    last_beat = (row == RW'(N1-1)) && (beat == BW'(N2-1));
    m_last    = m_valid && last_beat;
    m_data    = m_valid ? out_val : '0;
    m_addr    = AW'(patch) * AW'(N1*N2) + AW'(row) * AW'(N2) + AW'(beat);
  end

  // FIFO storage writes (data only, no reset needed)
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N1; i++) begin
      if (push_ok[i]) mem[i][wr_ptr[i][PA-1:0]] <= D[i];
    end
  end

  // FIFO pointers and sticky overflow flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N1; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
      overflow <= '0;
    end else begin
      for (int unsigned i = 0; i < N1; i++) begin
        if (push_ok[i])              wr_ptr[i]   <= wr_ptr[i] + 1'b1;
        if (valid_D[i] && !push_ok[i]) overflow[i] <= 1'b1;
        if (pop[i])                  rd_ptr[i]   <= rd_ptr[i] + 1'b1;
      end
    end
  end

  // Drain FSM: row/beat/patch walk and end-of-matrix done pulse.
  // Row 0 is presented already in IDLE so data pushed at one edge can be
  // accepted right after it; the state mirrors whether a patch is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      row   <= '0;
      beat  <= '0;
      patch <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE:    if (!empty[0]) state <= DRAIN;
        DRAIN:   state <= DRAIN;
        default: state <= IDLE;
      endcase
      if (hs) begin
        if (beat == BW'(N2-1)) begin
          beat <= '0;
          if (row == RW'(N1-1)) begin
            row   <= '0;
            state <= IDLE;
            if (patch == PW'(NP-1)) begin
              patch <= '0;
              done  <= 1'b1;
            end else begin
              patch <= patch + 1'b1;
            end
          end else begin
            row <= row + 1'b1;
          end
        end else begin
          beat <= beat + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_systolic_drain.sv
// Self-checking bench for systolic_drain (N1=N2=2, M=4, FIFO_DEPTH=4).
// Reference: per-row queues plus a global beat count; the expected row,
// address and end-of-patch flag all follow from that count.
module tb_systolic_drain;

  localparam int N1 = 2, N2 = 2, M = 4, DEPTH = 4, DW = 16, OW = 8;
  localparam int BEATS = M*M;

  logic            clk = 1'b0;
  logic            rst;
  logic [DW-1:0]   D [N1-1:0];
  logic [N1-1:0]   valid_D;
  logic [OW-1:0]   m_data;
  logic [3:0]      m_addr;
  logic            m_valid;
  logic            m_ready;
  logic            m_last;
  logic            done;
  logic [N1-1:0]   overflow;

  systolic_drain #(
    .D_W_ACC(DW), .D_W_OUT(OW), .N1(N1), .N2(N2), .M(M), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .D(D), .valid_D(valid_D), .m_data(m_data),
    .m_addr(m_addr), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  // reference model state
  int          q [N1][$];
  int          n_beats;
  logic [1:0]  ovf_exp;
  logic        done_exp;

  function automatic int exp_out(int v);
`ifdef SYSTOLIC_DRAIN_SAT_EN
    return (v > 255) ? 255 : v;
`else
    return v & 255;
`endif
  endfunction

  function automatic int cur_row();
    return (n_beats / N2) % N1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N1; i++) q[i].delete();
    n_beats  = 0;
    ovf_exp  = '0;
    done_exp = 1'b0;
  endtask

  // Per-cycle comparison of every output against the model
  task automatic compare();
    int  r;
    bit  ev;
    r  = cur_row();
    ev = (q[r].size() > 0);
    check("m_valid", m_valid, ev);
    if (ev) begin
      check("m_data", m_data, exp_out(q[r][0]));
      check("m_addr", m_addr, n_beats % BEATS);
      check("m_last", m_last, (n_beats % (N1*N2)) == (N1*N2 - 1));
    end else begin
      check("m_last_idle", m_last, 0);
    end
    check("done", done, done_exp);
    check("overflow", overflow, ovf_exp);
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then compare
  task automatic step(input logic [1:0] vd, input int d0, input int d1, input logic rdy);
    bit hs;
    int r;
    r = cur_row();
    hs = (q[r].size() > 0) && rdy;
    valid_D = vd;
    D[0]    = d0[DW-1:0];
    D[1]    = d1[DW-1:0];
    m_ready = rdy;
    @(posedge clk);
    if (hs) void'(q[r].pop_front());
    for (int i = 0; i < N1; i++) begin
      if (vd[i]) begin
        if (q[i].size() < DEPTH) q[i].push_back(i == 0 ? d0 & 16'hFFFF : d1 & 16'hFFFF);
        else ovf_exp[i] = 1'b1;
      end
    end
    done_exp = hs && ((n_beats % BEATS) == BEATS - 1);
    if (hs) n_beats++;
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    valid_D = '0;
    m_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_done", done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_addr", m_addr, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    valid_D = '0; D[0] = '0; D[1] = '0; m_ready = 1'b0; rst = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // staggered burst {1,2},{3,4}: beats 1..4 at addr 0..3, last on the 4th
    step(2'b01, 1, 0, 1'b1);
    check("t1_first_valid", m_valid, 1);
    check("t1_first_data", m_data, 1);
    step(2'b11, 2, 3, 1'b1);
    check("t1_addr1", m_addr, 1);
    step(2'b10, 0, 4, 1'b1);
    check("t1_data3", m_data, 3);
    step(2'b00, 0, 0, 1'b1);
    check("t1_data4", m_data, 4);
    check("t1_last", m_last, 1);
    check("t1_addr3", m_addr, 3);
    step(2'b00, 0, 0, 1'b1);
    check("t1_drained", m_valid, 0);

    // saturation vs truncation, then 5 pushes to row 1 while stalled
    step(2'b01, 16'h0123, 0, 1'b0);
`ifdef SYSTOLIC_DRAIN_SAT_EN
    check("t5_sat", m_data, 8'hFF);
`else
    check("t5_trunc", m_data, 8'h23);
`endif
    for (int i = 0; i < 5; i++) step(2'b10, 0, 10 + i, 1'b0);
    check("t4_overflow", overflow, 2'b10);
    for (int i = 0; i < 8; i++) step(2'b01, 20 + i, 0, 1'b1);

    // reset mid-patch after two beats drained
    do_reset();
    step(2'b11, 5, 6, 1'b1);
    step(2'b11, 7, 8, 1'b1);
    step(2'b00, 0, 0, 1'b1);
    check("t6_two_drained", m_addr, 2);
    do_reset();
    step(2'b01, 9, 0, 1'b1);
    check("t6_restart_addr", m_addr, 0);
    check("t6_restart_data", m_data, 9);

    // alternating ready with steady traffic
    for (int c = 0; c < 200; c++)
      step(2'($urandom_range(0, 3)), $urandom_range(0, 1023), $urandom_range(0, 1023), c[0]);

    // randomized traffic with occasional reset
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset();
      step(2'($urandom_range(0, 3)), $urandom_range(0, 1023), $urandom_range(0, 1023),
           $urandom_range(0, 3) != 0);
    end

    // drain out with ready held high and no new traffic
    for (int c = 0; c < 20; c++) step(2'b00, 0, 0, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
